// File: rtl/qkv_pkg.sv
// Shared types and constants for the projection output SRAM readers/writers.
package qkv_pkg;

  localparam int OUT_ADDR_W     = 7;
  localparam int OUT_DATA_W     = 128;
  localparam int OUT_MEM_DEPTH  = 128;
  localparam int WORDS_PER_TILE = 4;
  localparam int RD_FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_t;

  // A request can never cover more than the whole SRAM.
  function automatic logic [7:0] clamp_words(input logic [7:0] n);
    return (n > 8'(OUT_MEM_DEPTH)) ? 8'(OUT_MEM_DEPTH) : n;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with simultaneous push/pop and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // Storage, pointers and count; push and pop may both happen in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/output_mem_reader.sv
// Streams FP32 tile rows out of the projection output SRAM onto a
// valid/ready interface. SRAM data returning while the FIFO is empty is
// forwarded straight to the output so a ready consumer sees one word per cycle.
//
//   state  | meaning
//   IDLE   | waiting for start
//   STREAM | issuing reads while buffer space allows
//   DRAIN  | all reads issued; waiting for the buffer to empty
module output_mem_reader
  import qkv_pkg::*;
#(
  parameter int ADDR_W     = OUT_ADDR_W,
  parameter int DATA_W     = OUT_DATA_W,
  parameter int MEM_DEPTH  = OUT_MEM_DEPTH,
  parameter int FIFO_DEPTH = RD_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        num_words,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] OUTPUT_MEM_DOUT,
  output logic              OUTPUT_MEM_CEB,
  output logic              OUTPUT_MEM_WEN,
  output logic [ADDR_W-1:0] OUTPUT_MEM_ADDR,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        m_word,
  output logic              m_last
);

  localparam int ENTRY_W = DATA_W + 3;
  localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

  rd_state_t          state;
  logic [7:0]         remaining;
  logic [1:0]         issue_word;
  logic               pend;
  logic               pend_last;
  logic [1:0]         pend_word;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] pend_entry;
  logic [ENTRY_W-1:0] out_entry;
  logic [CNT_W:0]     occ;
  logic               fifo_nonempty;
  logic               hs;
  logic               fifo_pop;
  logic               push;
  logic               issue;

  assign fifo_nonempty = (fifo_count != '0);
  assign m_valid       = fifo_nonempty || pend;
  assign hs            = m_valid && m_ready;
  assign fifo_pop      = hs && fifo_nonempty;
  // A returning word is buffered unless it goes straight out this cycle.
  assign push          = pend && !(hs && !fifo_nonempty);
  assign pend_entry    = {pend_last, pend_word, OUTPUT_MEM_DOUT};

  // Words held or in flight after this cycle's handshake, before any new read.
  assign occ   = {1'b0, fifo_count} + (CNT_W+1)'(pend) - (CNT_W+1)'(hs);
  assign issue = (state == STREAM) && (remaining != 8'd0) && (occ < DEPTH_C);

  assign OUTPUT_MEM_CEB = !issue;
  assign OUTPUT_MEM_WEN = 1'b1;

  // Output word: buffered head first, otherwise the word arriving from SRAM.
  always_comb begin
    out_entry = '0;
    if (fifo_nonempty) out_entry = fifo_head;
    else if (pend)     out_entry = pend_entry;
  end

  assign {m_last, m_word, m_data} = out_entry;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pend_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Track the single-cycle SRAM read latency together with the word's tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_last <= 1'b0;
      pend_word <= '0;
    end else begin
      pend      <= issue;
      pend_last <= (remaining == 8'd1);
      pend_word <= issue_word;
    end
  end

  // Request sequencing, address generation and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      OUTPUT_MEM_ADDR <= '0;
      remaining       <= '0;
      issue_word      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            OUTPUT_MEM_ADDR <= base_addr;
            remaining       <= clamp_words(num_words);
            issue_word      <= '0;
            busy            <= 1'b1;
            state           <= (num_words == 8'd0) ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (issue) begin
            OUTPUT_MEM_ADDR <= (OUTPUT_MEM_ADDR == ADDR_W'(MEM_DEPTH-1)) ?
                               '0 : OUTPUT_MEM_ADDR + 1'b1;
            remaining       <= remaining - 8'd1;
            issue_word      <= issue_word + 2'd1;
            if (remaining == 8'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (occ == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
